// File: rtl/cmd_unit_routed.sv
`default_nettype none
// ============================================================================
// Module   : cmd_unit_routed
// Purpose  : Tagged out-of-order command unit. Responses return only to the
//            issuing cluster. Define CMD_UNIT_ROUTED_STATS_EN for the
//            stat_issued_o / stat_resp_o counters.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_unit_routed #(
    parameter int NUM_CLUSTERS       = 4,
    parameter int NUM_CMD_INTERFACES = 2,
    parameter int CMD_W              = 64,
    parameter int RESP_W             = 32,
    parameter int MAX_INFLIGHT       = 8,
    parameter int TAG_W              = $clog2(MAX_INFLIGHT),
    parameter int SEL_W              = (NUM_CMD_INTERFACES > 1) ? $clog2(NUM_CMD_INTERFACES) : 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [NUM_CLUSTERS-1:0]                    cmd_valid_i,
    output logic [NUM_CLUSTERS-1:0]                    cmd_ready_o,
    input  logic [NUM_CLUSTERS-1:0][CMD_W-1:0]         cmd_data_i,
    input  logic [NUM_CLUSTERS-1:0][SEL_W-1:0]         cmd_intf_i,
    output logic [NUM_CLUSTERS-1:0]                    cmd_resp_valid_o,
    input  logic [NUM_CLUSTERS-1:0]                    cmd_resp_ready_i,
    output logic [NUM_CLUSTERS-1:0][RESP_W-1:0]        cmd_resp_data_o,
    output logic [NUM_CMD_INTERFACES-1:0]              intf_valid_o,
    input  logic [NUM_CMD_INTERFACES-1:0]              intf_ready_i,
    output logic [NUM_CMD_INTERFACES-1:0][CMD_W-1:0]   intf_data_o,
    output logic [NUM_CMD_INTERFACES-1:0][TAG_W-1:0]   intf_tag_o,
    input  logic [NUM_CMD_INTERFACES-1:0]              intf_resp_valid_i,
    input  logic [NUM_CMD_INTERFACES-1:0][TAG_W-1:0]   intf_resp_tag_i,
    input  logic [NUM_CMD_INTERFACES-1:0][RESP_W-1:0]  intf_resp_data_i,
    output logic [NUM_CMD_INTERFACES-1:0][TAG_W:0]     intf_inflight_o,
    output logic [NUM_CMD_INTERFACES-1:0]              err_bad_tag_o,
    output logic [NUM_CLUSTERS-1:0]                    err_bad_intf_o
`ifdef CMD_UNIT_ROUTED_STATS_EN
    ,
    output logic [NUM_CMD_INTERFACES-1:0][31:0]        stat_issued_o,
    output logic [NUM_CMD_INTERFACES-1:0][31:0]        stat_resp_o
`endif
);

    localparam int c_cid_w  = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
    localparam int c_flat   = NUM_CMD_INTERFACES * MAX_INFLIGHT;
    localparam int c_flat_w = $clog2(c_flat);

    localparam logic [1:0] c_free = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    // Slots are stored flat: index = interface * MAX_INFLIGHT + tag.
    logic [1:0]         r_slot_state [c_flat];
    logic [c_cid_w-1:0] r_slot_owner [c_flat];
    logic [RESP_W-1:0]  r_slot_data  [c_flat];

    logic [NUM_CMD_INTERFACES-1:0]             r_intf_valid;
    logic [NUM_CMD_INTERFACES-1:0][CMD_W-1:0]  r_intf_data;
    logic [NUM_CMD_INTERFACES-1:0][TAG_W-1:0]  r_intf_tag;
    logic [c_cid_w-1:0]                        r_rr_issue [NUM_CMD_INTERFACES];
    logic [NUM_CMD_INTERFACES-1:0][TAG_W:0]    r_inflight;
    logic [NUM_CMD_INTERFACES-1:0]             r_err_bad_tag;

    logic [NUM_CLUSTERS-1:0]              r_resp_valid;
    logic [NUM_CLUSTERS-1:0][RESP_W-1:0]  r_resp_data;
    logic [c_flat_w-1:0]                  r_rr_ret [NUM_CLUSTERS];
    logic [NUM_CLUSTERS-1:0]              r_err_bad_intf;

    logic [NUM_CMD_INTERFACES-1:0]           w_grant;
    logic [NUM_CMD_INTERFACES-1:0]           w_slot_avail;
    logic [NUM_CMD_INTERFACES-1:0]           w_req_hit;
    logic [c_cid_w-1:0]                      w_grant_c   [NUM_CMD_INTERFACES];
    logic [TAG_W-1:0]                        w_alloc_tag [NUM_CMD_INTERFACES];
    logic [NUM_CMD_INTERFACES-1:0][TAG_W:0]  w_inflight;
    logic [NUM_CLUSTERS-1:0]                 w_bad_intf;
    logic [NUM_CLUSTERS-1:0]                 w_ret_load;
    logic [c_flat_w-1:0]                     w_ret_idx [NUM_CLUSTERS];

    function automatic logic [c_cid_w-1:0] cid_at(input logic [c_cid_w-1:0] base, input int k);
        return c_cid_w'((int'(base) + k) % NUM_CLUSTERS);
    endfunction

    function automatic logic [c_flat_w-1:0] flat_at(input logic [c_flat_w-1:0] base, input int k);
        return c_flat_w'((int'(base) + k) % c_flat);
    endfunction

    always_comb begin
        w_bad_intf = '0;
        for (int c = 0; c < NUM_CLUSTERS; c++) begin
            w_bad_intf[c] = !rst_i && cmd_valid_i[c] && (int'(cmd_intf_i[c]) >= NUM_CMD_INTERFACES);
        end
    end

    // Descending scans leave the lowest free tag and the first requester after the pointer.
    always_comb begin
        w_grant      = '0;
        w_slot_avail = '0;
        w_req_hit    = '0;
        for (int i = 0; i < NUM_CMD_INTERFACES; i++) begin
            w_grant_c[i]   = '0;
            w_alloc_tag[i] = '0;
            for (int t = MAX_INFLIGHT - 1; t >= 0; t--) begin
                if (r_slot_state[i*MAX_INFLIGHT + t] == c_free) begin
                    w_slot_avail[i] = 1'b1;
                    w_alloc_tag[i]  = TAG_W'(t);
                end
            end
            for (int k = NUM_CLUSTERS - 1; k >= 0; k--) begin
                if (cmd_valid_i[cid_at(r_rr_issue[i], k)] &&
                    int'(cmd_intf_i[cid_at(r_rr_issue[i], k)]) == i) begin
                    w_req_hit[i] = 1'b1;
                    w_grant_c[i] = cid_at(r_rr_issue[i], k);
                end
            end
            w_grant[i] = !rst_i && w_slot_avail[i] && w_req_hit[i] &&
                         (!r_intf_valid[i] || intf_ready_i[i]);
        end
    end

    always_comb begin
        cmd_ready_o = w_bad_intf;
        for (int i = 0; i < NUM_CMD_INTERFACES; i++) begin
            if (w_grant[i]) begin
                cmd_ready_o[w_grant_c[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_ret_load = '0;
        for (int c = 0; c < NUM_CLUSTERS; c++) begin
            w_ret_idx[c] = '0;
            if (!r_resp_valid[c] || cmd_resp_ready_i[c]) begin
                for (int k = c_flat - 1; k >= 0; k--) begin
                    if (r_slot_state[flat_at(r_rr_ret[c], k)] == c_done &&
                        r_slot_owner[flat_at(r_rr_ret[c], k)] == c_cid_w'(c)) begin
                        w_ret_load[c] = 1'b1;
                        w_ret_idx[c]  = flat_at(r_rr_ret[c], k);
                    end
                end
            end
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < NUM_CMD_INTERFACES; i++) begin
            for (int t = 0; t < MAX_INFLIGHT; t++) begin
                if (r_slot_state[i*MAX_INFLIGHT + t] != c_free) begin
                    w_inflight[i] = w_inflight[i] + (TAG_W+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int f = 0; f < c_flat; f++) begin
                r_slot_state[f] <= c_free;
                r_slot_owner[f] <= '0;
                r_slot_data[f]  <= '0;
            end
            for (int i = 0; i < NUM_CMD_INTERFACES; i++) begin
                r_rr_issue[i] <= '0;
            end
            for (int c = 0; c < NUM_CLUSTERS; c++) begin
                r_rr_ret[c] <= '0;
            end
            r_intf_valid   <= '0;
            r_intf_data    <= '0;
            r_intf_tag     <= '0;
            r_inflight     <= '0;
            r_err_bad_tag  <= '0;
            r_resp_valid   <= '0;
            r_resp_data    <= '0;
            r_err_bad_intf <= '0;
        end else begin
            r_inflight     <= w_inflight;
            r_err_bad_intf <= r_err_bad_intf | w_bad_intf;
            for (int i = 0; i < NUM_CMD_INTERFACES; i++) begin
                if (intf_ready_i[i]) begin
                    r_intf_valid[i] <= 1'b0;
                end
                if (w_grant[i]) begin
                    r_intf_valid[i] <= 1'b1;
                    r_intf_data[i]  <= cmd_data_i[w_grant_c[i]];
                    r_intf_tag[i]   <= w_alloc_tag[i];
                    r_slot_state[i*MAX_INFLIGHT + int'(w_alloc_tag[i])] <= c_busy;
                    r_slot_owner[i*MAX_INFLIGHT + int'(w_alloc_tag[i])] <= w_grant_c[i];
                    r_rr_issue[i]   <= cid_at(w_grant_c[i], 1);
                end
                // Allocation targets a FREE slot, so it never collides with a BUSY response.
                if (intf_resp_valid_i[i]) begin
                    if (r_slot_state[i*MAX_INFLIGHT + int'(intf_resp_tag_i[i])] == c_busy) begin
                        r_slot_state[i*MAX_INFLIGHT + int'(intf_resp_tag_i[i])] <= c_done;
                        r_slot_data[i*MAX_INFLIGHT + int'(intf_resp_tag_i[i])]  <= intf_resp_data_i[i];
                    end else begin
                        r_err_bad_tag[i] <= 1'b1;
                    end
                end
            end
            for (int c = 0; c < NUM_CLUSTERS; c++) begin
                if (cmd_resp_ready_i[c]) begin
                    r_resp_valid[c] <= 1'b0;
                end
                if (w_ret_load[c]) begin
                    r_resp_valid[c]            <= 1'b1;
                    r_resp_data[c]             <= r_slot_data[w_ret_idx[c]];
                    r_slot_state[w_ret_idx[c]] <= c_free;
                    r_rr_ret[c]                <= flat_at(w_ret_idx[c], 1);
                end
            end
        end
    end

`ifdef CMD_UNIT_ROUTED_STATS_EN
    logic [NUM_CMD_INTERFACES-1:0][31:0] r_stat_issued;
    logic [NUM_CMD_INTERFACES-1:0][31:0] r_stat_resp;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stat_issued <= '0;
            r_stat_resp   <= '0;
        end else begin
            for (int i = 0; i < NUM_CMD_INTERFACES; i++) begin
                if (r_intf_valid[i] && intf_ready_i[i]) begin
                    r_stat_issued[i] <= r_stat_issued[i] + 32'd1;
                end
                if (intf_resp_valid_i[i] &&
                    r_slot_state[i*MAX_INFLIGHT + int'(intf_resp_tag_i[i])] == c_busy) begin
                    r_stat_resp[i] <= r_stat_resp[i] + 32'd1;
                end
            end
        end
    end

    assign stat_issued_o = r_stat_issued;
    assign stat_resp_o   = r_stat_resp;
`endif

    assign intf_valid_o     = r_intf_valid;
    assign intf_data_o      = r_intf_data;
    assign intf_tag_o       = r_intf_tag;
    assign intf_inflight_o  = r_inflight;
    assign err_bad_tag_o    = r_err_bad_tag;
    assign cmd_resp_valid_o = r_resp_valid;
    assign cmd_resp_data_o  = r_resp_data;
    assign err_bad_intf_o   = r_err_bad_intf;

endmodule
`default_nettype wire
